uart_msg_source: RTL and testbench

Byte-stream generator that sits directly upstream of the UART transmitter in the tile top level. It repeatedly emits the 10-byte ASCII message "HELLO nn\r\n", where nn is a two-digit decimal message counter. Bytes go over a valid/ready handshake into the transmitter's byte input, with a programmable idle gap between messages.

---
 rtl/uart_msg_pkg.sv | 37 +++
 rtl/uart_msg_source_bcd_counter.sv | 27 ++
 rtl/uart_msg_source.sv | 105 ++++++++++
 tb/tb_uart_msg_source.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_msg_pkg.sv
// Shared constants for the UART message source: FSM states, message template
// and the helper that maps a byte index plus BCD digits to the outgoing byte.
package uart_msg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int MSG_LEN = 10;
  localparam logic [3:0] LAST_IDX        = 4'(MSG_LEN - 1);
  localparam logic [3:0] DIGIT_TENS_IDX  = 4'd6;
  localparam logic [3:0] DIGIT_UNITS_IDX = 4'd7;
  localparam logic [7:0] ASCII_ZERO      = 8'h30;

  // "HELLO nn\r\n"; entry [0] is the first byte, digit slots hold placeholders.
  localparam logic [MSG_LEN-1:0][7:0] MSG_TEMPLATE = {
    8'h0A, 8'h0D, 8'h00, 8'h00, 8'h20, 8'h4F, 8'h4C, 8'h4C, 8'h45, 8'h48
  };

  function automatic logic [7:0] msg_byte(input logic [3:0] idx,
                                          input logic [3:0] tens,
                                          input logic [3:0] units);
    logic [7:0] b;
    b = 8'h00;
    if (idx == DIGIT_TENS_IDX) begin
      b = ASCII_ZERO + {4'h0, tens};
    end else if (idx == DIGIT_UNITS_IDX) begin
      b = ASCII_ZERO + {4'h0, units};
    end else if (idx < 4'(MSG_LEN)) begin
      b = MSG_TEMPLATE[idx];
    end
    return b;
  endfunction

endpackage

// File: rtl/uart_msg_source_bcd_counter.sv
// Two-digit BCD message counter, 00..99 with wrap, plus a binary copy.
module bcd_counter_2d (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [6:0] bin
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (inc) begin
      if (units == 4'd9) begin
        units <= 4'd0;
        tens  <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

  assign bin = 7'(tens) * 7'd10 + 7'(units);

endmodule

// File: rtl/uart_msg_source.sv
// Emits "HELLO nn\r\n" repeatedly over a registered valid/ready byte port,
// with a fixed idle gap between messages and a BCD message counter.
module uart_msg_source
  import uart_msg_pkg::*;
#(
  parameter int CLOCK_RATE = 1000,
  parameter int GAP_CYCLES = CLOCK_RATE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic [6:0] msg_count,
  output logic [1:0] state_dbg
);

  // Handshake: a byte moves on a rising edge with tx_valid=1 and tx_ready=1.
  // Once raised, tx_valid and tx_data hold until that edge; both are
  // registered and never depend combinationally on tx_ready.

  localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

  state_t      state;
  logic [3:0]  idx;
  logic [15:0] gap_cnt;
  logic [3:0]  tens;
  logic [3:0]  units;
  logic        xfer;
  logic        last_xfer;

  assign xfer      = tx_valid && tx_ready;
  assign last_xfer = (state == SEND) && xfer && (idx == LAST_IDX);

  bcd_counter_2d u_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (last_xfer),
    .tens  (tens),
    .units (units),
    .bin   (msg_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= 4'd0;
      gap_cnt  <= 16'd0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state    <= SEND;
            idx      <= 4'd0;
            tx_valid <= 1'b1;
            tx_data  <= msg_byte(4'd0, tens, units);
          end
        end
        SEND: begin
          if (xfer) begin
            if (idx == LAST_IDX) begin
              state    <= GAP;
              idx      <= 4'd0;
              gap_cnt  <= GAP_LOAD;
              tx_valid <= 1'b0;
              tx_data  <= 8'h00;
            end else begin
              // Digits are loaded from the counter, which only moves at the
              // final transfer, so they stay constant across a message.
              idx     <= idx + 4'd1;
              tx_data <= msg_byte(idx + 4'd1, tens, units);
            end
          end
        end
        GAP: begin
          if (gap_cnt == 16'd0) begin
            if (enable) begin
              state    <= SEND;
              idx      <= 4'd0;
              tx_valid <= 1'b1;
              tx_data  <= msg_byte(4'd0, tens, units);
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
          tx_data  <= 8'h00;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_msg_source.sv
// Directed bench for uart_msg_source with GAP_CYCLES=4: reset, free-run,
// backpressure, counter wrap, enable drop and mid-message reset.
module tb_uart_msg_source;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic [6:0] msg_count;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int n_xfer = 0;
  logic       bp_mode = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int         bp_ph = 0;
  logic [7:0] exp_q[$];

  uart_msg_source #(.CLOCK_RATE(1000), .GAP_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .msg_count (msg_count),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // model of the message contents
  task automatic push_msg(input int n);
    exp_q.push_back(8'h48); exp_q.push_back(8'h45); exp_q.push_back(8'h4C);
    exp_q.push_back(8'h4C); exp_q.push_back(8'h4F); exp_q.push_back(8'h20);
    exp_q.push_back(8'(8'h30 + n / 10));
    exp_q.push_back(8'(8'h30 + n % 10));
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
  endtask

  // one clock: drive tx_ready, score any transfer, check stall hold afterwards
  task automatic cycle();
    logic [7:0] held;
    logic       was_stall;
    tx_ready = bp_mode ? bp_pat[bp_ph] : 1'b1;
    bp_ph = (bp_ph + 1) % 4;
    was_stall = tx_valid && !tx_ready && reset;
    held = tx_data;
    if (tx_valid && tx_ready && reset) begin
      n_xfer++;
      if (exp_q.size() == 0) check("unexpected_byte", {24'h0, tx_data}, 32'h100);
      else check("byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
    end
    @(posedge clk); #1;
    if (was_stall) check("stall_hold", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, held});
  endtask

  task automatic drain(input int left);
    int guard;
    guard = 0;
    while (exp_q.size() > left && guard < 200) begin
      cycle();
      guard++;
    end
    check("drain", 32'(exp_q.size()), 32'(left));
    while (exp_q.size() > left) void'(exp_q.pop_front());
  endtask

  task automatic send_msg(input int n);
    push_msg(n);
    drain(0);
  endtask

  task automatic measure_gap(output int g);
    g = 0;
    while (!tx_valid && g < 50) begin
      g++;
      cycle();
    end
  endtask

  initial begin
    int g;
    int x0;
    int gb;
    logic seen;
    reset    = 1'b0;
    enable   = 1'b1;
    tx_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_data", {24'h0, tx_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_count", {25'h0, msg_count}, 32'h0);
    check("rst_state", {30'h0, state_dbg}, 32'h0);

    reset = 1'b1;
    cycle();
    check("first_valid", {31'h0, tx_valid}, 32'h1);
    check("first_data", {24'h0, tx_data}, 32'h48);
    check("first_busy", {31'h0, busy}, 32'h1);

    // free-running
    send_msg(0);
    check("count_after_msg0", {25'h0, msg_count}, 32'd1);
    check("busy_in_gap", {31'h0, busy}, 32'h1);
    measure_gap(g);
    check("gap0", 32'(g), 32'd4);
    send_msg(1);
    measure_gap(g);
    check("gap1", 32'(g), 32'd4);

    // backpressure 1,0,0,1
    bp_mode = 1'b1;
    bp_ph = 0;
    x0 = n_xfer;
    send_msg(2);
    check("bp_handshakes", 32'(n_xfer - x0), 32'd10);
    measure_gap(g);
    check("bp_gap", 32'(g), 32'd4);
    bp_mode = 1'b0;

    // counter wrap
    for (int m = 3; m < 100; m++) begin
      send_msg(m);
      if (m == 98) check("count_99", {25'h0, msg_count}, 32'd99);
      measure_gap(g);
    end
    check("count_wrap", {25'h0, msg_count}, 32'd0);
    send_msg(0);
    measure_gap(g);
    check("gap_after_wrap", 32'(g), 32'd4);

    // enable drop after byte 3
    push_msg(1);
    drain(6);
    enable = 1'b0;
    drain(0);
    check("drop_count", {25'h0, msg_count}, 32'd2);
    gb = 0;
    while (busy && gb < 50) begin
      gb++;
      cycle();
    end
    check("drop_gap", 32'(gb), 32'd4);
    seen = 1'b0;
    repeat (20) begin
      seen = seen | tx_valid | busy;
      cycle();
    end
    check("drop_idle", {31'h0, seen}, 32'h0);
    check("drop_state", {30'h0, state_dbg}, 32'h0);

    // reset with index 5 offered and stalled
    enable = 1'b1;
    push_msg(2);
    drain(5);
    tx_ready = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", {31'h0, tx_valid}, 32'h0);
    check("mid_rst_count", {25'h0, msg_count}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_data", {24'h0, tx_data}, 32'h0);
    exp_q.delete();
    reset = 1'b1;
    send_msg(0);
    check("post_rst_count", {25'h0, msg_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
